hk_wb_arbiter: RTL

- Round-robin arbiter and sequencer that shares the exported housekeeping Wishbone port (hk_*) of the openframe project wrapper between NREQ internal user-logic requesters.
- Each requester presents a classic single-transfer Wishbone request. The arbiter grants one requester at a time and drives the registered hk_* master signals.
- It returns ack/data to the granted requester. Requesters are, for example, a UART bridge, a debug port and a flash loader.

---
 rtl/hk_wb_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/hk_wb_arbiter.sv
// Round-robin arbiter sharing the housekeeping Wishbone port among NREQ requesters; IDLE->BUS->RESP, all outputs registered.
// Defining HK_ARB_TIMEOUT_EN adds a bus timeout that aborts a stalled transfer with req_err.
module hk_wb_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                      core_clk,
  input  logic                      core_rstn,
  input  logic [NREQ-1:0]           req_stb,
  input  logic [NREQ-1:0]           req_we,
  input  logic [4*NREQ-1:0]         req_sel,
  input  logic [32*NREQ-1:0]        req_adr,
  input  logic [32*NREQ-1:0]        req_wdat,
  output logic [NREQ-1:0]           req_ack,
  output logic [NREQ-1:0]           req_err,
  output logic [31:0]               req_rdat,
  output logic                      hk_stb_o,
  output logic                      hk_we_o,
  output logic [3:0]                hk_sel_o,
  output logic [31:0]               hk_adr_o,
  output logic [31:0]               hk_dat_o,
  input  logic                      hk_ack_i,
  input  logic [31:0]               hk_dat_i,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
);

  localparam int          IW     = $clog2(NREQ);
  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("hk_wb_arbiter: NREQ must be 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("hk_wb_arbiter: TIMEOUT must be 1..65535");
  end

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   last, last_n, gid_n, pick;
  logic [IW:0]     cand;
  logic            found;
  logic            stb_n, we_n;
  logic [3:0]      sel_n;
  logic [31:0]     adr_n, dat_n, rdat_n;
  logic [NREQ-1:0] ack_n;

  // Scan last+NREQ down to last+1 so the nearest requester after last wins.
  always_comb begin
    found = 1'b0;
    pick  = last;
    cand  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = {1'b0, last} + (IW+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (req_stb[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

`ifdef HK_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_M1 = 16'(TIMEOUT - 1);
  logic [15:0]     cnt, cnt_n;
  logic [NREQ-1:0] err_n;
`endif

  always_comb begin
    state_n = state;
    last_n  = last;
    gid_n   = grant_id;
    stb_n   = hk_stb_o;
    we_n    = hk_we_o;
    sel_n   = hk_sel_o;
    adr_n   = hk_adr_o;
    dat_n   = hk_dat_o;
    rdat_n  = req_rdat;
    ack_n   = '0;
`ifdef HK_ARB_TIMEOUT_EN
    cnt_n   = cnt;
    err_n   = '0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_n = BUS;
          stb_n   = 1'b1;
          we_n    = req_we[pick];
          sel_n   = req_sel[4*pick +: 4];
          adr_n   = req_adr[32*pick +: 32];
          dat_n   = req_wdat[32*pick +: 32];
          gid_n   = pick;
          last_n  = pick;
`ifdef HK_ARB_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end
      end
      BUS: begin
        if (hk_ack_i) begin
          state_n         = RESP;
          stb_n           = 1'b0;
          ack_n[grant_id] = 1'b1;
          rdat_n          = hk_dat_i;
        end
`ifdef HK_ARB_TIMEOUT_EN
        // An ack on the expiry cycle takes precedence over the abort.
        else if (cnt == TO_M1) begin
          state_n         = RESP;
          stb_n           = 1'b0;
          err_n[grant_id] = 1'b1;
          rdat_n          = '0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
`endif
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state    <= IDLE;
      last     <= IW'(NREQ - 1);
      grant_id <= '0;
      hk_stb_o <= 1'b0;
      hk_we_o  <= 1'b0;
      hk_sel_o <= '0;
      hk_adr_o <= '0;
      hk_dat_o <= '0;
      req_rdat <= '0;
      req_ack  <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      last     <= last_n;
      grant_id <= gid_n;
      hk_stb_o <= stb_n;
      hk_we_o  <= we_n;
      hk_sel_o <= sel_n;
      hk_adr_o <= adr_n;
      hk_dat_o <= dat_n;
      req_rdat <= rdat_n;
      req_ack  <= ack_n;
      busy     <= (state_n != IDLE);
    end
  end

`ifdef HK_ARB_TIMEOUT_EN
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      cnt     <= '0;
      req_err <= '0;
    end else begin
      cnt     <= cnt_n;
      req_err <= err_n;
    end
  end
`else
  assign req_err = '0;
`endif

endmodule
